mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Sequencer for the MAC column array and its key/query SRAMs. On a start request it performs two phases:
- Key-load phase: streams load_len key words from kmem with inst=01 so every column latches its key.
- Execute phase: streams num_q query words from qmem with inst=10, throttled by output-FIFO backpressure.
It then waits for the array pipeline to drain, pulses done and returns to idle. It sits between the top-level core FSM and the mac_array/mac_col chain.

Parameters:
- load_len, 9, key-load cycles; equals the column count plus 1 so the last column's counter matches.
- drain_len, 12, cycles waited after the last execute before done (column skew plus the 2-stage fifo_wr delay).
- addr_bw, 4, width of SRAM addresses and of num_q.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- num_q  input  addr_bw  query count; captured on accepted start
- ofifo_full  input  1  output FIFO cannot accept a new row
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- kmem_rd  output  1  key SRAM read enable
- kmem_addr  output  addr_bw  key SRAM address
- qmem_rd  output  1  query SRAM read enable
- qmem_addr  output  addr_bw  query SRAM address
- inst  output  2  array instruction; [1] execute, [0] load
- q_issued  output  addr_bw  number of queries issued in the current run

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0, all outputs are 0 and the state is IDLE, including when reset is asserted mid-run. No output may glitch high on reset release.
- States: IDLE, LOAD, EXEC, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 captures num_q into nq_q, clears the address counter and q_issued, and moves to LOAD.
  - busy=1 from the next cycle.
- LOAD:
  - kmem_rd=1 with kmem_addr = 0, 1, ..., load_len-1 on consecutive cycles.
  - After the cycle with addr=load_len-1: go to EXEC, or to DRAIN if nq_q==0.
  - LOAD is never stalled by ofifo_full.
- SRAM latency: reads have 1-cycle latency, so inst is kmem_rd/qmem_rd delayed one cycle.
  - inst[0] = kmem_rd delayed by 1.
  - inst[1] = (qmem_rd delayed by 1) AND the issue was not stalled.
  - inst is never 11.
  - Exactly load_len cycles of inst=01 per run; exactly nq_q cycles of inst=10.
- EXEC:
  - When ofifo_full=0: qmem_rd=1, qmem_addr = current count, count and q_issued increment.
  - When ofifo_full=1: qmem_rd=0, address and count hold, and the following cycle's inst=00 (an array bubble).
  - After the issue where count reaches nq_q-1: go to DRAIN.
  - ofifo_full is sampled combinationally into the registered next-state/enable logic; a full that rises in the same cycle as an issue decision blocks that issue.
- DRAIN:
  - Counts drain_len cycles after the last inst=10 (or the last inst=01 when nq_q==0). No reads; inst=00.
  - ofifo_full is ignored.
  - Then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in this cycle is ignored.
- start while busy: ignored. num_q changes during a run have no effect.
- Wrap-around: num_q is at most 2^addr_bw-1. q_issued and qmem_addr never wrap within a run.
- Latency, with no stalls, from the accepted start edge to the done pulse: 1 + load_len + nq_q + drain_len + 1 cycles. Each stalled cycle adds exactly 1.

Test Plan:
- Reset, then start with num_q=4 and ofifo_full=0:
  - kmem_addr 0..8 over 9 cycles; inst=01 for 9 cycles lagging by 1.
  - qmem_addr 0..3; inst=10 for 4 cycles.
  - done exactly 1+9+4+12+1=27 cycles after start; q_issued=4.
- num_q=0: no qmem_rd and no inst=10; done 23 cycles after start.
- num_q=5 with ofifo_full=1 for 3 cycles after the second issue:
  - qmem_addr holds at 2 during the stall; three inst=00 bubbles.
  - Exactly 5 inst=10 cycles; done delayed by 3 relative to the no-stall run.
- Pulse start during LOAD, EXEC and DONE: no restart, no change in address sequence or done timing; q_issued unaffected.
- Drive reset=0 mid-EXEC (e.g. qmem_addr=2):
  - All outputs 0 immediately (asynchronous), state IDLE after release.
  - A new start with num_q=2 runs cleanly from kmem_addr 0.
- Throughout every test:
  - inst is never 11.
  - kmem_rd and qmem_rd are never high together.
  - busy and done are never high together.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Sequencer for the MAC column array: streams key words from kmem, then query
// words from qmem under output-FIFO backpressure, drains the pipeline and pulses done.
module mac_array_ctrl #(
    parameter int load_len  = 9,
    parameter int drain_len = 12,
    parameter int addr_bw   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] num_q,
    input  logic               ofifo_full,
    output logic               busy,
    output logic               done,
    output logic               kmem_rd,
    output logic [addr_bw-1:0] kmem_addr,
    output logic               qmem_rd,
    output logic [addr_bw-1:0] qmem_addr,
    output logic [1:0]         inst,
    output logic [addr_bw-1:0] q_issued
);

    localparam int CW = (addr_bw > $clog2(load_len)) ? addr_bw : $clog2(load_len);
    localparam int DW = $clog2(drain_len + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      LOAD_LAST = CW'(load_len - 1);
    localparam logic [DW-1:0]      DRN_ONE   = DW'(1);
    // The drain counter starts on the edge that issues the final read, so it
    // also covers the SRAM latency cycle before the last array instruction.
    localparam logic [DW-1:0]      DRN_LAST  = DW'(drain_len + 1);
    localparam logic [addr_bw-1:0] Q_ONE     = addr_bw'(1);

    logic [2:0]         state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [DW-1:0]      dcnt_reg, dcnt_next;
    logic [addr_bw-1:0] nq_reg, nq_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               kmem_rd_reg, kmem_rd_next;
    logic [addr_bw-1:0] kmem_addr_reg, kmem_addr_next;
    logic               qmem_rd_reg, qmem_rd_next;
    logic [addr_bw-1:0] qmem_addr_reg, qmem_addr_next;
    logic [1:0]         inst_reg, inst_next;
    logic [addr_bw-1:0] q_issued_reg, q_issued_next;
    logic [CW-1:0]      cnt_inc;

    assign cnt_inc = cnt_reg + CNT_ONE;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dcnt_next      = dcnt_reg;
        nq_next        = nq_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        kmem_rd_next   = 1'b0;
        kmem_addr_next = kmem_addr_reg;
        qmem_rd_next   = 1'b0;
        qmem_addr_next = qmem_addr_reg;
        q_issued_next  = q_issued_reg;
        // Array instruction follows the SRAM read by one cycle; a stalled
        // issue leaves qmem_rd low and so becomes a bubble.
        inst_next      = {qmem_rd_reg, kmem_rd_reg};

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next     = S_LOAD;
                    busy_next      = 1'b1;
                    cnt_next       = '0;
                    nq_next        = num_q;
                    q_issued_next  = '0;
                    kmem_addr_next = '0;
                    qmem_addr_next = '0;
                end
            end
            S_LOAD: begin
                kmem_rd_next   = 1'b1;
                kmem_addr_next = cnt_reg[addr_bw-1:0];
                if (cnt_reg == LOAD_LAST) begin
                    cnt_next   = '0;
                    dcnt_next  = '0;
                    state_next = (nq_reg == '0) ? S_DRAIN : S_EXEC;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_EXEC: begin
                qmem_addr_next = cnt_reg[addr_bw-1:0];
                if (!ofifo_full) begin
                    qmem_rd_next  = 1'b1;
                    q_issued_next = q_issued_reg + Q_ONE;
                    cnt_next      = cnt_inc;
                    if (cnt_inc == CW'(nq_reg)) begin
                        dcnt_next  = '0;
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_reg == DRN_LAST) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    dcnt_next = dcnt_reg + DRN_ONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            dcnt_reg      <= '0;
            nq_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            kmem_rd_reg   <= 1'b0;
            kmem_addr_reg <= '0;
            qmem_rd_reg   <= 1'b0;
            qmem_addr_reg <= '0;
            inst_reg      <= 2'b00;
            q_issued_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dcnt_reg      <= dcnt_next;
            nq_reg        <= nq_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            kmem_rd_reg   <= kmem_rd_next;
            kmem_addr_reg <= kmem_addr_next;
            qmem_rd_reg   <= qmem_rd_next;
            qmem_addr_reg <= qmem_addr_next;
            inst_reg      <= inst_next;
            q_issued_reg  <= q_issued_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign kmem_rd   = kmem_rd_reg;
    assign kmem_addr = kmem_addr_reg;
    assign qmem_rd   = qmem_rd_reg;
    assign qmem_addr = qmem_addr_reg;
    assign inst      = inst_reg;
    assign q_issued  = q_issued_reg;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed, table-driven bench for mac_array_ctrl: per-run latency, instruction
// counts, address sequences, start/reset corner cases and global invariants.
module tb_mac_array_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] num_q;
    logic       ofifo_full;
    logic       busy;
    logic       done;
    logic       kmem_rd;
    logic [3:0] kmem_addr;
    logic       qmem_rd;
    logic [3:0] qmem_addr;
    logic [1:0] inst;
    logic [3:0] q_issued;

    int total  = 0;
    int passed = 0;
    int inv_err = 0;

    typedef struct {
        logic [3:0] nq;     // query count for this run
        int         stall;  // full cycles inserted after the second issue
        bit         pulse;  // extra start pulses in LOAD, EXEC and DONE
        bit         full_x; // full held during LOAD and DRAIN (must be ignored)
        int         lat;    // expected cycles from start edge to done
    } tv_t;

    tv_t vec [7];

    mac_array_ctrl #(.load_len(9), .drain_len(12), .addr_bw(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_q      (num_q),
        .ofifo_full (ofifo_full),
        .busy       (busy),
        .done       (done),
        .kmem_rd    (kmem_rd),
        .kmem_addr  (kmem_addr),
        .qmem_rd    (qmem_rd),
        .qmem_addr  (qmem_addr),
        .inst       (inst),
        .q_issued   (q_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (inst == 2'b11 || (kmem_rd && qmem_rd) || (busy && done))
                inv_err++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            passed++;
    endtask

    function automatic int outs_word();
        return int'({busy, done, kmem_rd, kmem_addr, qmem_rd, qmem_addr, inst, q_issued});
    endfunction

    task automatic run(input int idx, input tv_t v);
        int cyc, done_cyc, n01, n10, bubbles, kexp, qexp, nqrd, seq_err, stall_left, qi;
        cyc = -1; done_cyc = -1; n01 = 0; n10 = 0; bubbles = 0;
        kexp = 0; qexp = 0; nqrd = 0; seq_err = 0; stall_left = 0; qi = -1;
        num_q = v.nq;
        ofifo_full = v.full_x;
        start = 1'b1;
        @(posedge clk);
        while (done_cyc < 0 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (inst == 2'b01) n01++;
            if (inst == 2'b10) n10++;
            if (inst == 2'b00 && n10 > 0 && n10 < int'(v.nq)) bubbles++;
            if (kmem_rd) begin
                if (int'(kmem_addr) != kexp) seq_err++;
                kexp++;
            end
            if (qmem_rd) begin
                if (int'(qmem_addr) != qexp) seq_err++;
                qexp++;
                nqrd++;
            end else if (nqrd > 0 && nqrd < int'(v.nq) && int'(qmem_addr) != qexp) begin
                seq_err++;
            end
            if (cyc == 0) chk($sformatf("busy_after_start[%0d]", idx), int'(busy), 1);
            if (done) begin
                done_cyc = cyc;
                qi = int'(q_issued);
            end
            start = v.pulse && (cyc == 3 || cyc == 12 || done);
            num_q = v.nq ^ 4'hF;
            if (v.stall > 0 && qmem_rd && qmem_addr == 4'd1) stall_left = v.stall;
            if (stall_left > 0) begin
                ofifo_full = 1'b1;
                stall_left--;
            end else begin
                ofifo_full = v.full_x && (cyc <= 8 || cyc >= 9 + int'(v.nq));
            end
        end
        chk($sformatf("latency[%0d]", idx), done_cyc, v.lat);
        chk($sformatf("inst01_count[%0d]", idx), n01, 9);
        chk($sformatf("inst10_count[%0d]", idx), n10, int'(v.nq));
        chk($sformatf("qmem_rd_count[%0d]", idx), nqrd, int'(v.nq));
        chk($sformatf("q_issued_at_done[%0d]", idx), qi, int'(v.nq));
        chk($sformatf("bubbles[%0d]", idx), bubbles, v.stall);
        chk($sformatf("addr_seq_errors[%0d]", idx), seq_err, 0);
        @(negedge clk);
        start = 1'b0;
        ofifo_full = 1'b0;
        chk($sformatf("no_restart_after_done[%0d]", idx), int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        $display("run %0d: nq=%0d stall=%0d pulse=%0d full_x=%0d done_at=%0d inst10=%0d",
                 idx, v.nq, v.stall, v.pulse, v.full_x, done_cyc, n10);
    endtask

    initial begin
        int guard;
        tv_t rv;
        vec[0] = '{nq: 4'd4,  stall: 0, pulse: 1'b0, full_x: 1'b0, lat: 27};
        vec[1] = '{nq: 4'd0,  stall: 0, pulse: 1'b0, full_x: 1'b0, lat: 23};
        vec[2] = '{nq: 4'd5,  stall: 3, pulse: 1'b0, full_x: 1'b0, lat: 31};
        vec[3] = '{nq: 4'd1,  stall: 0, pulse: 1'b0, full_x: 1'b0, lat: 24};
        vec[4] = '{nq: 4'd15, stall: 0, pulse: 1'b0, full_x: 1'b0, lat: 38};
        vec[5] = '{nq: 4'd4,  stall: 0, pulse: 1'b1, full_x: 1'b0, lat: 27};
        vec[6] = '{nq: 4'd3,  stall: 0, pulse: 1'b0, full_x: 1'b1, lat: 26};

        reset = 1'b0;
        start = 1'b0;
        num_q = 4'd0;
        ofifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("outputs_in_reset", outs_word(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("outputs_after_release", outs_word(), 0);

        for (int i = 0; i < 7; i++) run(i, vec[i]);

        // Asynchronous reset in the middle of EXEC
        num_q = 4'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(qmem_rd && qmem_addr == 4'd2) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_exec_addr2", int'(qmem_rd && qmem_addr == 4'd2), 1);
        #2 reset = 1'b0;
        #1 chk("outputs_async_reset", outs_word(), 0);
        $display("reset asserted mid-EXEC, outputs=%0h", outs_word());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_release", outs_word(), 0);
        rv = '{nq: 4'd2, stall: 0, pulse: 1'b0, full_x: 1'b0, lat: 25};
        run(7, rv);

        chk("invariant_violations", inv_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
